// File: rtl/lightbike_input_hub_if.sv
// Bus bundle for lightbike_input_hub: PS/2 byte strobe, round/overflow control,
// and the per-player command queue read side.
interface lightbike_input_hub_if #(
   parameter int NUM_PLAYERS = 2
);
   logic                     ps2_valid;
   logic [7:0]               ps2_byte;
   logic                     game_reset;
   logic                     clear_ovf;
   logic [NUM_PLAYERS-1:0]   rd_en;
   logic [NUM_PLAYERS-1:0]   rd_valid;
   logic [2*NUM_PLAYERS-1:0] rd_dir;
   logic [2*NUM_PLAYERS-1:0] cur_dir;
   logic [NUM_PLAYERS-1:0]   overflow;

   modport master (
      output ps2_valid, ps2_byte, game_reset, clear_ovf, rd_en,
      input  rd_valid, rd_dir, cur_dir, overflow
   );

   modport slave (
      input  ps2_valid, ps2_byte, game_reset, clear_ovf, rd_en,
      output rd_valid, rd_dir, cur_dir, overflow
   );
endinterface

// File: rtl/lightbike_input_hub.sv
// PS/2 scancode parser feeding per-player direction command queues for lightbike steering.
// Define LB_REVERSE_BLOCK_EN to also drop commands that reverse a bike onto itself.
module lightbike_input_hub #(
   parameter int NUM_PLAYERS = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 clock,
   input  logic                 resetn,
   lightbike_input_hub_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
`ifdef LB_REVERSE_BLOCK_EN
   localparam bit REV_BLOCK = 1'b1;
`else
   localparam bit REV_BLOCK = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   // Returns {hit, player, dir}; one scancode maps to at most one player.
   function automatic logic [4:0] decode_key(input logic ext, input logic [7:0] b);
      logic [4:0] r;
      r = '0;
      if (ext) begin
         case (b)
            8'h75:   r = {1'b1, 2'd1, 2'd0};
            8'h6B:   r = {1'b1, 2'd1, 2'd1};
            8'h72:   r = {1'b1, 2'd1, 2'd2};
            8'h74:   r = {1'b1, 2'd1, 2'd3};
            default: r = '0;
         endcase
      end else begin
         case (b)
            8'h1D:   r = {1'b1, 2'd0, 2'd0};
            8'h1C:   r = {1'b1, 2'd0, 2'd1};
            8'h1B:   r = {1'b1, 2'd0, 2'd2};
            8'h23:   r = {1'b1, 2'd0, 2'd3};
            8'h43:   r = {1'b1, 2'd2, 2'd0};
            8'h3B:   r = {1'b1, 2'd2, 2'd1};
            8'h42:   r = {1'b1, 2'd2, 2'd2};
            8'h4B:   r = {1'b1, 2'd2, 2'd3};
            8'h75:   r = {1'b1, 2'd3, 2'd0};
            8'h6B:   r = {1'b1, 2'd3, 2'd1};
            8'h73:   r = {1'b1, 2'd3, 2'd2};
            8'h74:   r = {1'b1, 2'd3, 2'd3};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   function automatic logic [1:0] init_dir(input int p);
      case (p)
         0:       return 2'd3;
         1:       return 2'd1;
         2:       return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   state_t     state_q, state_d;
   logic       dec_en, dec_ext;
   logic [4:0] key_p0;
   logic       key_hit_p0;

   logic       cmd_vld_p1;
   logic [1:0] cmd_player_p1;
   logic [1:0] cmd_dir_p1;

   logic [1:0]    mem      [NUM_PLAYERS][FIFO_DEPTH];
   logic [AW-1:0] wr_ptr   [NUM_PLAYERS];
   logic [AW-1:0] rd_ptr   [NUM_PLAYERS];
   logic [CW-1:0] count    [NUM_PLAYERS];
   logic [1:0]    last_dir [NUM_PLAYERS];
   logic [1:0]    cur_dir  [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] ovf_q;

   logic [NUM_PLAYERS-1:0]   want, full, pop, push, ovf_set, not_empty;
   logic [2*NUM_PLAYERS-1:0] rd_dir_v, cur_dir_v;

   // Stage p0: scancode parser
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      dec_en  = 1'b0;
      dec_ext = 1'b0;
      if (bus.ps2_valid) begin
         case (state_q)
            IDLE: begin
               if (bus.ps2_byte == 8'hE0)      state_d = EXT;
               else if (bus.ps2_byte == 8'hF0) state_d = BRK;
               else                            dec_en  = 1'b1;
            end
            EXT: begin
               if (bus.ps2_byte == 8'hF0)      state_d = EXT_BRK;
               else if (bus.ps2_byte == 8'hE0) state_d = EXT;
               else begin
                  dec_en  = 1'b1;
                  dec_ext = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (bus.game_reset) begin
         state_d = IDLE;
         dec_en  = 1'b0;
      end
   end

   assign key_p0     = decode_key(dec_ext, bus.ps2_byte);
   assign key_hit_p0 = dec_en && key_p0[4] && (int'(key_p0[3:2]) < NUM_PLAYERS);

   // Stage p1: registered command, pushed on the following edge
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)             cmd_vld_p1 <= 1'b0;
      else if (bus.game_reset) cmd_vld_p1 <= 1'b0;
      else                     cmd_vld_p1 <= key_hit_p0;
   end

   always_ff @(posedge clock) begin
      if (key_hit_p0) begin
         cmd_player_p1 <= key_p0[3:2];
         cmd_dir_p1    <= key_p0[1:0];
      end
   end

   // Push filtering: duplicates (and optionally reversals) are dropped before the full check
   always_comb begin
      want      = '0;
      full      = '0;
      pop       = '0;
      push      = '0;
      ovf_set   = '0;
      not_empty = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         not_empty[p] = (count[p] != '0);
         full[p]      = (count[p] == CW'(FIFO_DEPTH));
         pop[p]       = bus.rd_en[p] && not_empty[p];
         want[p]      = cmd_vld_p1 && (cmd_player_p1 == 2'(p))
                        && (cmd_dir_p1 != last_dir[p])
                        && !(REV_BLOCK && (cmd_dir_p1 == (last_dir[p] ^ 2'd2)));
         push[p]      = want[p] && (!full[p] || pop[p]);
         ovf_set[p]   = want[p] && full[p] && !pop[p];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            wr_ptr[p]   <= '0;
            rd_ptr[p]   <= '0;
            count[p]    <= '0;
            last_dir[p] <= init_dir(p);
            cur_dir[p]  <= init_dir(p);
         end
         ovf_q <= '0;
      end else if (bus.game_reset) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            wr_ptr[p]   <= '0;
            rd_ptr[p]   <= '0;
            count[p]    <= '0;
            last_dir[p] <= init_dir(p);
            cur_dir[p]  <= init_dir(p);
         end
         ovf_q <= '0;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (push[p]) begin
               wr_ptr[p]   <= wr_ptr[p] + AW'(1);
               last_dir[p] <= cmd_dir_p1;
            end
            if (pop[p]) begin
               rd_ptr[p]  <= rd_ptr[p] + AW'(1);
               cur_dir[p] <= mem[p][rd_ptr[p]];
            end
            if (push[p] && !pop[p])      count[p] <= count[p] + CW'(1);
            else if (pop[p] && !push[p]) count[p] <= count[p] - CW'(1);
            // Set beats a simultaneous clear so a drop is never lost
            if (ovf_set[p])         ovf_q[p] <= 1'b1;
            else if (bus.clear_ovf) ovf_q[p] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (push[p]) mem[p][wr_ptr[p]] <= cmd_dir_p1;
      end
   end

   always_comb begin
      rd_dir_v  = '0;
      cur_dir_v = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         rd_dir_v[2*p +: 2]  = not_empty[p] ? mem[p][rd_ptr[p]] : 2'd0;
         cur_dir_v[2*p +: 2] = cur_dir[p];
      end
   end

   assign bus.rd_valid = not_empty;
   assign bus.rd_dir   = rd_dir_v;
   assign bus.cur_dir  = cur_dir_v;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_lightbike_input_hub.sv
// Directed bench for lightbike_input_hub (4 players, depth 4, reverse blocking off).
module tb_lightbike_input_hub;

   localparam int NP = 4;
   localparam int FD = 4;

   logic clock;
   logic resetn;
   int   n_chk;
   int   n_pass;

   lightbike_input_hub_if #(.NUM_PLAYERS(NP)) bus ();

   lightbike_input_hub #(.NUM_PLAYERS(NP), .FIFO_DEPTH(FD)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      bus.ps2_valid = 1'b1;
      bus.ps2_byte  = b;
      @(negedge clock);
      bus.ps2_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic pop_p(input int p);
      @(negedge clock);
      bus.rd_en[p] = 1'b1;
      @(negedge clock);
      bus.rd_en = '0;
   endtask

   initial begin
      logic [1:0] exp_heads [4];
      n_chk  = 0;
      n_pass = 0;
      resetn         = 1'b0;
      bus.ps2_valid  = 1'b0;
      bus.ps2_byte   = 8'h00;
      bus.game_reset = 1'b0;
      bus.clear_ovf  = 1'b0;
      bus.rd_en      = '0;
      #12;
      chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
      chk("reset_rd_dir",   32'(bus.rd_dir),   32'h0);
      chk("reset_overflow", 32'(bus.overflow), 32'h0);
      chk("reset_cur_dir",  32'(bus.cur_dir),  32'h27);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);

      // 1D: P0 up, two-edge latency
      @(negedge clock);
      bus.ps2_valid = 1'b1;
      bus.ps2_byte  = 8'h1D;
      @(negedge clock);
      bus.ps2_valid = 1'b0;
      chk("lat_one_edge", 32'(bus.rd_valid[0]), 32'h0);
      @(negedge clock);
      chk("lat_two_edge", 32'(bus.rd_valid[0]), 32'h1);
      chk("p0_head_up",   32'(bus.rd_dir[1:0]), 32'h0);

      send_byte(8'h1C);
      pop_p(0);
      chk("pop1_cur",  32'(bus.cur_dir[1:0]), 32'h0);
      chk("pop1_head", 32'(bus.rd_dir[1:0]),  32'h1);
      pop_p(0);
      chk("pop2_cur",   32'(bus.cur_dir[1:0]), 32'h1);
      chk("pop2_empty", 32'(bus.rd_valid[0]),  32'h0);

      // P1 duplicate, extended break, then parser back in IDLE
      send_byte(8'hE0);
      send_byte(8'h6B);
      chk("p1_dup_drop", 32'(bus.rd_valid), 32'h0);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      chk("ext_break_none", 32'(bus.rd_valid), 32'h0);
      send_byte(8'h1B);
      chk("idle_after_brk", 32'(bus.rd_valid), 32'h1);
      chk("p0_head_down",   32'(bus.rd_dir),   32'h2);
      pop_p(0);
      chk("pop_down_cur", 32'(bus.cur_dir[1:0]), 32'h2);

      // Reversal accepted in this build; duplicate still dropped
      send_byte(8'h23);
      pop_p(0);
      send_byte(8'h1C);
      chk("reverse_accept", 32'(bus.rd_valid[0]), 32'h1);
      chk("reverse_head",   32'(bus.rd_dir[1:0]), 32'h1);
      pop_p(0);
      send_byte(8'h1C);
      chk("p0_dup_drop", 32'(bus.rd_valid[0]), 32'h0);

      // Extended P1 and normal P2 maps
      send_byte(8'hE0);
      send_byte(8'h75);
      chk("p1_ext_up", 32'(bus.rd_valid), 32'h2);
      send_byte(8'h42);
      chk("p2_dup_drop", 32'(bus.rd_valid), 32'h2);
      send_byte(8'h4B);
      chk("p2_right_vld", 32'(bus.rd_valid), 32'h6);
      chk("p2_right_dir", 32'(bus.rd_dir),   32'h30);

      @(negedge clock);
      bus.game_reset = 1'b1;
      @(negedge clock);
      bus.game_reset = 1'b0;
      chk("grst_rd_valid", 32'(bus.rd_valid), 32'h0);
      chk("grst_cur_dir",  32'(bus.cur_dir),  32'h27);
      chk("grst_rd_dir",   32'(bus.rd_dir),   32'h0);

      // Fill P0 and overflow
      send_byte(8'h1D);
      send_byte(8'h1C);
      send_byte(8'h1B);
      send_byte(8'h23);
      chk("full_no_ovf", 32'(bus.overflow), 32'h0);
      send_byte(8'h1D);
      chk("ovf_set", 32'(bus.overflow), 32'h1);
      @(negedge clock);
      bus.clear_ovf = 1'b1;
      @(negedge clock);
      bus.clear_ovf = 1'b0;
      chk("ovf_clear", 32'(bus.overflow), 32'h0);

      // Set wins over same-edge clear
      @(negedge clock);
      bus.ps2_valid = 1'b1;
      bus.ps2_byte  = 8'h1B;
      @(negedge clock);
      bus.ps2_valid = 1'b0;
      bus.clear_ovf = 1'b1;
      @(negedge clock);
      bus.clear_ovf = 1'b0;
      chk("ovf_set_wins", 32'(bus.overflow[0]), 32'h1);
      @(negedge clock);
      bus.clear_ovf = 1'b1;
      @(negedge clock);
      bus.clear_ovf = 1'b0;
      chk("ovf_clear2", 32'(bus.overflow[0]), 32'h0);

      // Push into full queue with simultaneous pop
      @(negedge clock);
      bus.ps2_valid = 1'b1;
      bus.ps2_byte  = 8'h1D;
      @(negedge clock);
      bus.ps2_valid = 1'b0;
      bus.rd_en[0]  = 1'b1;
      @(negedge clock);
      bus.rd_en = '0;
      chk("fullpop_ovf",  32'(bus.overflow[0]), 32'h0);
      chk("fullpop_cur",  32'(bus.cur_dir[1:0]), 32'h0);
      exp_heads[0] = 2'd1;
      exp_heads[1] = 2'd2;
      exp_heads[2] = 2'd3;
      exp_heads[3] = 2'd0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_head%0d", i), 32'(bus.rd_dir[1:0]), 32'(exp_heads[i]));
         pop_p(0);
      end
      chk("drain_empty", 32'(bus.rd_valid[0]), 32'h0);

      // E0, game_reset, then 75 parsed as normal (P3 up, a duplicate)
      send_byte(8'h43);
      chk("p2_up_vld", 32'(bus.rd_valid), 32'h4);
      @(negedge clock);
      bus.ps2_valid = 1'b1;
      bus.ps2_byte  = 8'hE0;
      @(negedge clock);
      bus.ps2_valid  = 1'b0;
      bus.game_reset = 1'b1;
      @(negedge clock);
      bus.game_reset = 1'b0;
      chk("grst2_empty", 32'(bus.rd_valid), 32'h0);
      send_byte(8'h75);
      chk("grst_75_normal", 32'(bus.rd_valid), 32'h0);
      send_byte(8'h6B);
      chk("p3_left_vld", 32'(bus.rd_valid), 32'h8);
      chk("p3_left_dir", 32'(bus.rd_dir),   32'h40);

      // Async reset mid-sequence
      @(negedge clock);
      bus.ps2_valid = 1'b1;
      bus.ps2_byte  = 8'hE0;
      @(negedge clock);
      bus.ps2_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_vld", 32'(bus.rd_valid), 32'h0);
      chk("async_rst_cur", 32'(bus.cur_dir),  32'h27);
      @(negedge clock);
      resetn = 1'b1;
      send_byte(8'h1C);
      chk("post_rst_idle", 32'(bus.rd_valid), 32'h1);
      chk("post_rst_dir",  32'(bus.rd_dir),   32'h1);
      pop_p(1);
      chk("pop_empty_ign", 32'(bus.cur_dir),  32'h27);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
